// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
// Pipeline sequencer for the 5-stage core. Detects load-use hazards,
// data-memory wait states and taken branches/jumps, and drives the
// stall / bubble / flush controls of PC, IF_ID, ID_EX, EX_MEM and MEM_WB.
//
// Optional feature: define HAZARD_STATS_EN to build three saturating
// statistics counters. Without it the counter ports are tied to zero and no
// counter flops exist.
//
// Parameters
//   REG_W        register-address width
//   FLUSH_DEPTH  cycles IF_ID is flushed per taken branch/jump (1..7)
//   MAX_WAIT     data-memory wait cycles before timeout (2..2**16)
//   CNT_W        statistics counter width
//
// Ports
//   clk_i           clock, all state on rising edge
//   rst_i           synchronous reset, active-high
//   ifid_rs_i       rs field of instruction in ID
//   ifid_rt_i       rt field of instruction in ID
//   idex_rt_i       rt (load destination) of instruction in EX
//   idex_memread_i  instruction in EX is a load
//   branch_taken_i  branch/jump resolved taken in ID this cycle
//   mem_req_i       instruction in MEM accesses data memory
//   mem_ack_i       data memory completes access this cycle
//   pc_write_o      PC may update
//   ifid_stall_o    hold IF_ID
//   ifid_flush_o    load NOP into IF_ID
//   idex_stall_o    hold ID_EX (connects to ID_EX stall_i)
//   idex_bubble_o   select all-zero control inputs into ID_EX
//   exmem_stall_o   hold EX_MEM
//   memwb_bubble_o  zero MEM_WB control inputs (RegWrite=0)
//   mem_err_o       sticky data-memory timeout
//   lu_cnt_o        load-use stall cycles
//   mem_cnt_o       memory wait cycles
//   flush_cnt_o     flush cycles
//   dbg_state_o     current sequencer state (RUN=0, FLUSH=1, MEM_WAIT=2, HALT=3)
//
// Handshake with data memory: a request is outstanding while mem_req_i=1 and
// it completes in the cycle mem_ack_i=1. An ack in the first request cycle
// costs nothing; otherwise the whole pipeline freezes until the ack cycle,
// which itself is already a released (normal) cycle.
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
  parameter int REG_W       = 5,
  parameter int FLUSH_DEPTH = 1,
  parameter int MAX_WAIT    = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] ifid_rs_i,
  input  logic [REG_W-1:0] ifid_rt_i,
  input  logic [REG_W-1:0] idex_rt_i,
  input  logic             idex_memread_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_write_o,
  output logic             ifid_stall_o,
  output logic             ifid_flush_o,
  output logic             idex_stall_o,
  output logic             idex_bubble_o,
  output logic             exmem_stall_o,
  output logic             memwb_bubble_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] lu_cnt_o,
  output logic [CNT_W-1:0] mem_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [1:0]       dbg_state_o
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int FL_W   = 3;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_HALT     = 2'd3
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [FL_W-1:0]   fl_cnt;

  logic lu;
  logic mw;
  logic freeze;    // full pipeline freeze (memory wait or timeout)
  logic lu_stall;  // one-cycle load-use stall with ID_EX bubble
  logic flush;     // IF_ID receives a NOP

  // Register 0 is hard-wired, so a load into $0 never creates a dependency.
  assign lu = idex_memread_i && (idex_rt_i != '0) &&
              ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));
  assign mw = mem_req_i && !mem_ack_i;

  // Output decode: registered state plus current inputs. Reset forces the
  // idle pattern immediately so no residual stall leaks through.
  always_comb begin
    freeze   = 1'b0;
    lu_stall = 1'b0;
    flush    = 1'b0;
    case (state)
      ST_RUN: begin
        if (mw)                  freeze   = 1'b1;
        else if (lu)             lu_stall = 1'b1;
        else if (branch_taken_i) flush    = 1'b1;
      end
      ST_FLUSH: begin
        // ID holds a flushed slot here, so lu and branch_taken_i are ignored.
        if (mw) freeze = 1'b1;
        else    flush  = 1'b1;
      end
      ST_MEM_WAIT: begin
        if (!mem_ack_i) freeze = 1'b1;
      end
      default: begin
        freeze = 1'b1;
      end
    endcase
    if (rst_i) begin
      freeze   = 1'b0;
      lu_stall = 1'b0;
      flush    = 1'b0;
    end
  end

  assign pc_write_o     = !(freeze || lu_stall);
  assign ifid_stall_o   = freeze || lu_stall;
  assign ifid_flush_o   = flush;
  assign idex_stall_o   = freeze;
  assign idex_bubble_o  = lu_stall;
  assign exmem_stall_o  = freeze;
  assign memwb_bubble_o = freeze;
  assign mem_err_o      = (state == ST_HALT) && !rst_i;
  assign dbg_state_o    = state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
      fl_cnt   <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mw) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end else if (!lu && branch_taken_i && (FLUSH_DEPTH > 1)) begin
            state  <= ST_FLUSH;
            fl_cnt <= FL_W'(FLUSH_DEPTH - 1);
          end
        end
        ST_FLUSH: begin
          // fl_cnt is left untouched on a memory wait so the flush resumes
          // where it stopped once the access completes.
          if (mw) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end else if (fl_cnt <= FL_W'(1)) begin
            state  <= ST_RUN;
            fl_cnt <= '0;
          end else begin
            fl_cnt <= fl_cnt - FL_W'(1);
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ack_i) begin
            state    <= (fl_cnt != '0) ? ST_FLUSH : ST_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
            state <= ST_HALT;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: begin
          // Timeout is terminal until reset; a late ack is ignored.
          state <= ST_HALT;
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] lu_cnt;
  logic [CNT_W-1:0] mem_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             mem_evt;

  // HALT keeps the freeze but is not a wait cycle any more.
  assign mem_evt = freeze && (state != ST_HALT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lu_cnt    <= '0;
      mem_cnt   <= '0;
      flush_cnt <= '0;
    end else begin
      if (lu_stall && (lu_cnt != '1))   lu_cnt    <= lu_cnt + 1'b1;
      if (mem_evt && (mem_cnt != '1))   mem_cnt   <= mem_cnt + 1'b1;
      if (flush && (flush_cnt != '1))   flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign lu_cnt_o    = lu_cnt;
  assign mem_cnt_o   = mem_cnt;
  assign flush_cnt_o = flush_cnt;
`else
  assign lu_cnt_o    = '0;
  assign mem_cnt_o   = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
// Directed-vector bench for hazard_stall_ctrl (FLUSH_DEPTH=3, MAX_WAIT=8,
// CNT_W=8). Each stimulus cycle pushes the hand-computed control pattern
// (plus the expected statistics counters) into exp_q; a monitor on the
// falling edge pops and compares every cycle.
// Control vector bit order:
//   [7] pc_write [6] ifid_stall [5] ifid_flush [4] idex_stall
//   [3] idex_bubble [2] exmem_stall [1] memwb_bubble [0] mem_err
// -----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

  localparam int W = 32;  // 8 control bits + three 8-bit counters

  localparam logic [7:0] C_NORM = 8'h80;  // normal flow / reset pattern
  localparam logic [7:0] C_LU   = 8'h48;  // load-use stall
  localparam logic [7:0] C_FL   = 8'hA0;  // IF_ID flush
  localparam logic [7:0] C_FRZ  = 8'h56;  // memory-wait freeze
  localparam logic [7:0] C_HLT  = 8'h57;  // timeout freeze + mem_err

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] ifid_rs = '0, ifid_rt = '0, idex_rt = '0;
  logic       idex_memread = 1'b0, branch_taken = 1'b0;
  logic       mem_req = 1'b0, mem_ack = 1'b0;

  logic       pc_write, ifid_stall, ifid_flush, idex_stall, idex_bubble;
  logic       exmem_stall, memwb_bubble, mem_err;
  logic [7:0] lu_cnt, mem_cnt, flush_cnt;
  logic [1:0] dbg_state;

  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int vec_no  = 0;
  logic [7:0] m_lu = '0, m_mem = '0, m_fl = '0;

  hazard_stall_ctrl #(
    .REG_W(5), .FLUSH_DEPTH(3), .MAX_WAIT(8), .CNT_W(8)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .ifid_rs_i(ifid_rs), .ifid_rt_i(ifid_rt), .idex_rt_i(idex_rt),
    .idex_memread_i(idex_memread), .branch_taken_i(branch_taken),
    .mem_req_i(mem_req), .mem_ack_i(mem_ack),
    .pc_write_o(pc_write), .ifid_stall_o(ifid_stall), .ifid_flush_o(ifid_flush),
    .idex_stall_o(idex_stall), .idex_bubble_o(idex_bubble),
    .exmem_stall_o(exmem_stall), .memwb_bubble_o(memwb_bubble),
    .mem_err_o(mem_err),
    .lu_cnt_o(lu_cnt), .mem_cnt_o(mem_cnt), .flush_cnt_o(flush_cnt),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- driver ----------------
  task automatic step(input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] ex_rt, input logic memread,
                      input logic br, input logic req, input logic ack,
                      input logic r, input logic [7:0] ec);
    @(posedge clk);
    #1;
    ifid_rs = rs; ifid_rt = rt; idex_rt = ex_rt; idex_memread = memread;
    branch_taken = br; mem_req = req; mem_ack = ack; rst = r;
`ifdef HAZARD_STATS_EN
    exp_q.push_back({ec, m_lu, m_mem, m_fl});
`else
    exp_q.push_back({ec, 24'h0});
`endif
    // Counters are registered: this cycle's event shows up next cycle.
    if (r) begin
      m_lu = '0; m_mem = '0; m_fl = '0;
    end else begin
      if (ec == C_LU)  m_lu  = m_lu + 8'd1;
      if (ec == C_FRZ) m_mem = m_mem + 8'd1;
      if (ec[5])       m_fl  = m_fl + 8'd1;
    end
  endtask

  task automatic idle();
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM);
  endtask

  task automatic mem(input logic req, input logic ack, input logic [7:0] ec);
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, req, ack, 1'b0, ec);
  endtask

  task automatic branch(input logic [7:0] ec);
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ec);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      e = exp_q.pop_front();
      a = {pc_write, ifid_stall, ifid_flush, idex_stall, idex_bubble,
           exmem_stall, memwb_bubble, mem_err, lu_cnt, mem_cnt, flush_cnt};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL vec%0d: got ctl=%02h lu=%0d mem=%0d fl=%0d, want ctl=%02h lu=%0d mem=%0d fl=%0d",
                 vec_no, a[31:24], a[23:16], a[15:8], a[7:0],
                 e[31:24], e[23:16], e[15:8], e[7:0]);
      end
      vec_no++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);

    // Reset state and idle flow
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_NORM);
    idle();

    // Load-use on rs: one stall cycle, then normal
    step(5'd2, 5'd7, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_LU);
    step(5'd2, 5'd7, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM);
    // Load into $0: no hazard
    step(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM);
    // Load-use on rt
    step(5'd1, 5'd3, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_LU);
    // Matching register but not a load; load without a match
    step(5'd3, 5'd3, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM);
    step(5'd4, 5'd6, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM);

    // Memory wait: ack in 6th request cycle -> 5 freeze cycles
    repeat (5) mem(1'b1, 1'b0, C_FRZ);
    mem(1'b1, 1'b1, C_NORM);
    idle();
    // Ack in the first request cycle costs nothing
    mem(1'b1, 1'b1, C_NORM);
    idle();

    // Branch with FLUSH_DEPTH=3; a load-use and a new branch during FLUSH are ignored
    branch(C_FL);
    step(5'd2, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_FL);
    idle_flush();
    idle();

    // Memory wait in the 2nd flush cycle: flush pauses, resumes after ack
    branch(C_FL);
    mem(1'b1, 1'b0, C_FRZ);
    mem(1'b1, 1'b0, C_FRZ);
    mem(1'b1, 1'b1, C_NORM);
    mem(1'b0, 1'b0, C_FL);
    mem(1'b0, 1'b0, C_FL);
    idle();

    // Load-use together with a taken branch: stall only, flush next cycle
    step(5'd9, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_LU);
    branch(C_FL);
    idle_flush();
    idle_flush();
    idle();

    // Timeout: 8 freeze cycles, then HALT; late ack ignored; reset recovers
    repeat (8) mem(1'b1, 1'b0, C_FRZ);
    mem(1'b1, 1'b0, C_HLT);
    mem(1'b1, 1'b1, C_HLT);
    mem(1'b0, 1'b0, C_HLT);
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_NORM);
    idle();

    // Reset in the middle of a memory wait
    mem(1'b1, 1'b0, C_FRZ);
    mem(1'b1, 1'b0, C_FRZ);
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, C_NORM);
    idle();
    branch(C_FL);
    idle_flush();
    idle_flush();
    idle();

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Quiet inputs during a FLUSH cycle: IF_ID still flushed
  task automatic idle_flush();
    step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_FL);
  endtask

endmodule
